// File: rtl/instruction_fetch.sv
// Fetch front end: PC generation, req/ack instruction-memory fetch, and a
// 2-entry buffer toward decode with single-cycle redirect/flush.
module instruction_fetch #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc
);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  hold_addr;
  logic               busy;
  logic               drop;
  logic [1:0]         occ;
  logic [INSTR_W-1:0] word0, word1;
  logic [ADDR_W-1:0]  wpc0, wpc1;
  logic               ack_take;
  logic               push;
  logic               pop;

  // A dropped request keeps presenting its original address until acked,
  // while pc already holds the redirect target.
  assign imem_req    = rst_n & (busy | (occ != 2'd2));
  assign imem_addr   = drop ? hold_addr : pc;
  assign ack_take    = imem_req & imem_ack;
  assign push        = ack_take & ~drop & ~redirect_valid;
  assign pop         = instr_valid & ~stall & ~redirect_valid;
  assign instr_valid = (occ != 2'd0);
  assign instruction = word0;
  assign instr_pc    = wpc0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      hold_addr <= RESET_PC;
      busy      <= 1'b0;
      drop      <= 1'b0;
      occ       <= 2'd0;
    end else begin
      busy <= imem_req & ~imem_ack;
      if (redirect_valid) begin
        pc  <= redirect_pc;
        occ <= 2'd0;
        if (ack_take) begin
          drop <= 1'b0;
        end else if (imem_req && !drop) begin
          drop      <= 1'b1;
          hold_addr <= pc;
        end
      end else begin
        if (ack_take) begin
          if (drop) drop <= 1'b0;
          else      pc   <= pc + 1'b1;
        end
        case ({push, pop})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end
  end

  // Entry 0 is always the head; pushes fill the first free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word0 <= '0;
      word1 <= '0;
      wpc0  <= '0;
      wpc1  <= '0;
    end else if (!redirect_valid) begin
      case ({push, pop})
        2'b11: begin
          if (occ == 2'd2) begin
            word0 <= word1;
            wpc0  <= wpc1;
            word1 <= imem_rdata;
            wpc1  <= pc;
          end else begin
            word0 <= imem_rdata;
            wpc0  <= pc;
          end
        end
        2'b10: begin
          if (occ == 2'd0) begin
            word0 <= imem_rdata;
            wpc0  <= pc;
          end else begin
            word1 <= imem_rdata;
            wpc1  <= pc;
          end
        end
        2'b01: begin
          word0 <= word1;
          wpc0  <= wpc1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioral memory whose ack
// latency is selectable (0 = ack in the request cycle).
module tb_instruction_fetch;
  localparam int AW = 16;
  localparam int IW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          stall = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          instr_valid;
  logic [IW-1:0] instruction;
  logic [AW-1:0] instr_pc;
  logic [3:0]    lat = 4'd0;
  logic [3:0]    cnt;
  int            n_chk = 0;
  int            n_fail = 0;

  instruction_fetch #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instruction(instruction), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  // Memory: acks once the request has been held for lat cycles.
  assign imem_ack   = imem_req && (cnt == lat);
  assign imem_rdata = {8'h00, imem_addr};
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= 4'd0;
    else if (!imem_req || imem_ack) cnt <= 4'd0;
    else                           cnt <= cnt + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    step();
    step();
    chk("rst_req",   32'(imem_req), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", 32'(instruction), 0);
    chk("rst_pc",    32'(instr_pc), 0);
    chk("rst_addr",  32'(imem_addr), 0);

    // Zero-wait stream
    rst_n = 1'b1;
    #1;
    chk("c0_req",   32'(imem_req), 1);
    chk("c0_addr",  32'(imem_addr), 0);
    chk("c0_valid", 32'(instr_valid), 0);
    step();
    for (int k = 1; k <= 6; k++) begin
      chk("s1_addr",  32'(imem_addr), k);
      chk("s1_valid", 32'(instr_valid), 1);
      chk("s1_pc",    32'(instr_pc), k - 1);
      chk("s1_instr", 32'(instruction), k - 1);
      if (k < 6) step();
    end

    // Stall backpressure for 6 cycles
    stall = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("st_req",   32'(imem_req), 0);
      chk("st_valid", 32'(instr_valid), 1);
      chk("st_pc",    32'(instr_pc), 5);
    end
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rel_valid", 32'(instr_valid), 1);
      chk("rel_pc",    32'(instr_pc), 6 + k);
      chk("rel_addr",  32'(imem_addr), 7 + k);
    end

    // 3-cycle wait states
    lat = 4'd2;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      chk("ws_addr",  32'(imem_addr), k / 3);
      chk("ws_req",   32'(imem_req), 1);
      chk("ws_ack",   32'(imem_ack), 32'(k % 3 == 2));
      chk("ws_valid", 32'(instr_valid), 32'(k >= 3 && k % 3 == 0));
      if (k >= 3 && k % 3 == 0) chk("ws_pc", 32'(instr_pc), k / 3 - 1);
      step();
    end

    // Redirect while request to address 5 waits
    chk("rd_pre_valid", 32'(instr_valid), 1);
    chk("rd_pre_pc",    32'(instr_pc), 4);
    chk("rd_pre_addr",  32'(imem_addr), 5);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    step();
    redirect_valid = 1'b0;
    chk("rd_flush_valid", 32'(instr_valid), 0);
    chk("rd_hold_addr",   32'(imem_addr), 5);
    chk("rd_hold_req",    32'(imem_req), 1);
    step();
    chk("rd_drop_addr",  32'(imem_addr), 5);
    chk("rd_drop_ack",   32'(imem_ack), 1);
    chk("rd_drop_valid", 32'(instr_valid), 0);
    step();
    chk("rd_new_addr",  32'(imem_addr), 32'h100);
    chk("rd_new_valid", 32'(instr_valid), 0);
    step();
    step();
    chk("rd_new_ack", 32'(imem_ack), 1);
    step();
    chk("rd_first_valid", 32'(instr_valid), 1);
    chk("rd_first_pc",    32'(instr_pc), 32'h100);
    chk("rd_first_instr", 32'(instruction), 32'h000100);
    chk("rd_next_addr",   32'(imem_addr), 32'h101);

    // Redirect coincident with ack and stall
    lat = 4'd0;
    do_reset();
    stall = 1'b1;
    step();
    chk("co_pre_pc",   32'(instr_pc), 0);
    chk("co_pre_ack",  32'(imem_ack), 1);
    chk("co_pre_addr", 32'(imem_addr), 1);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect_valid = 1'b0;
    chk("co_valid", 32'(instr_valid), 0);
    chk("co_addr",  32'(imem_addr), 32'h40);
    chk("co_req",   32'(imem_req), 1);
    step();
    chk("co_new_valid", 32'(instr_valid), 1);
    chk("co_new_pc",    32'(instr_pc), 32'h40);
    chk("co_new_instr", 32'(instruction), 32'h000040);
    stall = 1'b0;

    // Wrap-around and reset mid-wait
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    chk("wr_addr0",  32'(imem_addr), 32'hFFFE);
    chk("wr_valid0", 32'(instr_valid), 0);
    step();
    chk("wr_addr1", 32'(imem_addr), 32'hFFFF);
    chk("wr_pc1",   32'(instr_pc), 32'hFFFE);
    chk("wr_ins1",  32'(instruction), 32'h00FFFE);
    step();
    chk("wr_addr2", 32'(imem_addr), 32'h0000);
    chk("wr_pc2",   32'(instr_pc), 32'hFFFF);
    step();
    chk("wr_addr3", 32'(imem_addr), 32'h0001);
    chk("wr_pc3",   32'(instr_pc), 32'h0000);
    chk("wr_ins3",  32'(instruction), 32'h000000);
    step();
    chk("wr_pc4", 32'(instr_pc), 32'h0001);
    lat = 4'd2;
    stall = 1'b1;
    step();
    chk("mw_valid", 32'(instr_valid), 1);
    chk("mw_pc",    32'(instr_pc), 32'h0001);
    chk("mw_req",   32'(imem_req), 1);
    chk("mw_addr",  32'(imem_addr), 32'h0002);
    rst_n = 1'b0;
    #1;
    chk("mr_req",   32'(imem_req), 0);
    chk("mr_valid", 32'(instr_valid), 0);
    chk("mr_instr", 32'(instruction), 0);
    chk("mr_pc",    32'(instr_pc), 0);
    chk("mr_addr",  32'(imem_addr), 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
